// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the bit-serial adder.
//   sa_state_t   - control FSM state encoding (IDLE, SHIFT, DONE)
//   cnt_width()  - bit width of the per-operation bit counter
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_t;

    // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    // Clamped to 1 so a degenerate width never yields a zero-width vector.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: single-bit combinational full-adder cell.
//   a, b  in  operand bits
//   cin   in  carry in
//   s     out sum bit      = a ^ b ^ cin
//   cout  out carry out    = (a & b) | (cin & (a ^ b))
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Propagate term is shared between sum and carry.
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit unsigned adder.
// Operands are accepted on an in_valid/in_ready handshake, added LSB-first
// one bit per clock through a single full-adder cell and a carry flop, and
// the result is offered on an out_valid/out_ready handshake.
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   a, b, cin valid
//   in_ready   out  block can accept operands (IDLE)
//   a, b       in   WIDTH-bit operands
//   cin        in   carry in
//   out_valid  out  sum/cout valid (DONE)
//   out_ready  in   consumer accepts the result
//   sum        out  (a + b + cin) mod 2^WIDTH
//   cout       out  bit WIDTH of a + b + cin
//   busy       out  operation in flight (SHIFT or DONE)
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    import serial_adder_pkg::*;

    localparam int unsigned CW = cnt_width(WIDTH);

    sa_state_t        state;
    sa_state_t        state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    logic             fa_s;
    logic             fa_c;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from the state register only
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            SHIFT:   busy      = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand shift registers, carry flop, sum shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry_q <= cin;
                        sum_sr  <= '0;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so after WIDTH shifts bit 0
                    // of the result has reached position 0.
                    sum_sr  <= {fa_s, sum_sr[WIDTH-1:1]};
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    carry_q <= fa_c;
                    // Hold at WIDTH-1 rather than wrapping when WIDTH is a
                    // power of two.
                    if (!last_bit) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    // DONE: result registers hold until the handshake.
                end
            endcase
        end
    end

    assign sum  = sum_sr;
    assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: directed vector table and hand-written
// corner-case sequences at WIDTH=8, plus randomized transactions at
// WIDTH=8 and WIDTH=16 checked against plain integer addition.
module tb_serial_adder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        cin_in;
    logic        out_ready;
    logic        in_valid8;
    logic        in_valid16;

    logic        in_ready8,  out_valid8,  cout8,  busy8;
    logic [7:0]  sum8;
    logic        in_ready16, out_valid16, cout16, busy16;
    logic [15:0] sum16;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a_in[7:0]),
        .b         (b_in[7:0]),
        .cin       (cin_in),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .sum       (sum8),
        .cout      (cout8),
        .busy      (busy8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a_in),
        .b         (b_in),
        .cin       (cin_in),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .sum       (sum16),
        .cout      (cout16),
        .busy      (busy16)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        cin;
        logic [7:0]  exp_sum;
        logic        exp_cout;
        int unsigned hold;
        bit          poke;
    } vec_t;

    vec_t        vecs [0:5];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_in_ready(input bit wide);
        return wide ? in_ready16 : in_ready8;
    endfunction
    function automatic logic get_out_valid(input bit wide);
        return wide ? out_valid16 : out_valid8;
    endfunction
    function automatic logic get_busy(input bit wide);
        return wide ? busy16 : busy8;
    endfunction
    function automatic logic [15:0] get_sum(input bit wide);
        return wide ? sum16 : {8'h00, sum8};
    endfunction
    function automatic logic get_cout(input bit wide);
        return wide ? cout16 : cout8;
    endfunction

    task automatic set_in_valid(input bit wide, input logic v);
        if (wide) in_valid16 = v;
        else      in_valid8  = v;
    endtask

    // One full transaction. exp_total is the (WIDTH+1)-bit reference result.
    // hold: cycles out_ready stays low after out_valid rises.
    // poke: keep in_valid high with junk operands during SHIFT and DONE.
    task automatic run_op(input bit wide, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input int unsigned hold, input bit poke,
                          input logic [16:0] exp_total, input string tag);
        int unsigned w;
        int unsigned lat;
        bit          got;
        logic [15:0] exp_sum;
        logic        exp_cout;
        w        = wide ? 16 : 8;
        exp_sum  = wide ? exp_total[15:0] : {8'h00, exp_total[7:0]};
        exp_cout = exp_total[w];

        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (get_in_ready(wide)) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, " ready_wait"}, 32'(got), 32'd1);

        a_in      = a;
        b_in      = b;
        cin_in    = c;
        out_ready = (hold == 0);
        set_in_valid(wide, 1'b1);
        @(posedge clk); #1;                 // accept edge
        set_in_valid(wide, 1'b0);
        if (poke) begin
            a_in   = 16'h00AA;
            b_in   = 16'h00AA;
            cin_in = 1'b1;
            set_in_valid(wide, 1'b1);
        end

        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (get_out_valid(wide)) break;
        end
        check({tag, " latency"}, lat, w);
        check({tag, " sum"}, 32'(get_sum(wide)), 32'(exp_sum));
        check({tag, " cout"}, 32'(get_cout(wide)), 32'(exp_cout));
        check({tag, " done_in_ready"}, 32'(get_in_ready(wide)), 32'd0);

        for (int k = 0; k < int'(hold); k++) begin
            @(posedge clk); #1;
            check({tag, " hold_out_valid"}, 32'(get_out_valid(wide)), 32'd1);
            check({tag, " hold_sum"}, 32'(get_sum(wide)), 32'(exp_sum));
            check({tag, " hold_cout"}, 32'(get_cout(wide)), 32'(exp_cout));
            check({tag, " hold_in_ready"}, 32'(get_in_ready(wide)), 32'd0);
            check({tag, " hold_busy"}, 32'(get_busy(wide)), 32'd1);
        end

        set_in_valid(wide, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;                 // result handshake edge
        check({tag, " post_out_valid"}, 32'(get_out_valid(wide)), 32'd0);
        check({tag, " post_in_ready"}, 32'(get_in_ready(wide)), 32'd1);

        if (poke) begin
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                check({tag, " no_extra_op"}, 32'({get_out_valid(wide), get_busy(wide)}), 32'd0);
            end
        end
    endtask

    initial begin
        bit          seen;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] exp;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0, 1'b0};
        vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 5, 1'b0};
        vecs[5] = '{8'h21, 8'h43, 1'b1, 8'h65, 1'b0, 2, 1'b1};

        rst_n      = 1'b0;
        in_valid8  = 1'b0;
        in_valid16 = 1'b0;
        out_ready  = 1'b0;
        a_in       = '0;
        b_in       = '0;
        cin_in     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready",  32'(in_ready8),  32'd1);
        check("reset out_valid", 32'(out_valid8), 32'd0);
        check("reset busy",      32'(busy8),      32'd0);
        check("reset sum",       32'(sum8),       32'd0);
        check("reset cout",      32'(cout8),      32'd0);
        check("reset in_ready16", 32'(in_ready16), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_op(1'b0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].cin,
                   vecs[i].hold, vecs[i].poke,
                   {8'h00, vecs[i].exp_cout, vecs[i].exp_sum}, $sformatf("vec%0d", i));
        end

        // Reset mid-operation, asserted for the edge where cnt==3.
        a_in      = 16'h0077;
        b_in      = 16'h0011;
        cin_in    = 1'b0;
        out_ready = 1'b1;
        in_valid8 = 1'b1;
        @(posedge clk); #1;                 // accept edge
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort in_ready",  32'(in_ready8),  32'd1);
        check("abort out_valid", 32'(out_valid8), 32'd0);
        check("abort sum",       32'(sum8),       32'd0);
        check("abort cout",      32'(cout8),      32'd0);
        check("abort busy",      32'(busy8),      32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid8) seen = 1'b1;
        end
        check("abort no_out_valid", 32'(seen), 32'd0);
        run_op(1'b0, 16'h0077, 16'h0011, 1'b0, 0, 1'b0, 17'h00088, "after_abort");

        // Randomized transactions against integer addition.
        for (int wsel = 0; wsel < 2; wsel++) begin
            for (int n = 0; n < 1000; n++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                if (wsel == 0) begin
                    ra  = {8'h00, ra[7:0]};
                    rb  = {8'h00, rb[7:0]};
                end
                exp = 17'(ra) + 17'(rb) + 17'(rc);
                run_op(wsel[0], ra, rb, rc, $urandom_range(0, 3), 1'b0, exp,
                       $sformatf("rnd w%0d #%0d a=%0h b=%0h c=%0d", wsel == 0 ? 8 : 16, n, ra, rb, rc));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
